csr_trap_seq: RTL and testbench

Trap-entry / mret sequencer and write-port arbiter for the machine-mode CSR file. Owns the CSR file's single write port and shares it between execute-stage CSR instructions and multi-cycle trap/mret sequences. During a sequence it stalls the pipeline, writes mepc/mcause/mstatus one per cycle, then issues a one-cycle PC redirect to the trap vector or to mepc.

---
 rtl/csr_trap_seq_pkg.sv | 25 ++
 rtl/csr_trap_target.sv | 27 ++
 rtl/csr_trap_seq.sv | 155 +++++++++++++++
 tb/tb_csr_trap_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_seq_pkg.sv
// Shared definitions for the machine-mode trap/mret sequencer: states, CSR indices,
// and mstatus bit positions.
package csr_trap_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TR_EPC    = 3'd1,
        TR_CAUSE  = 3'd2,
        TR_STATUS = 3'd3,
        MR_STATUS = 3'd4,
        REDIR     = 3'd5
    } state_t;

    localparam int unsigned CSR_IDX_W = 12;

    localparam logic [CSR_IDX_W-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_IDX_W-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_IDX_W-1:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_trap_target.sv
// Trap vector computation from mtvec and the latched cause.
// Vectored interrupt mode is compiled in only when CSR_TRAP_VECTORED_EN is defined.
module csr_trap_target #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] mtvec_q,
    input  logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] vector_pc
);

    logic [XLEN-1:0] base;
    logic            unused_cause;

    assign base = mtvec_q & ~XLEN'(3);

`ifdef CSR_TRAP_VECTORED_EN
    // Only interrupts are vectored; synchronous exceptions always land on base.
    logic vectored;
    assign vectored  = (mtvec_q[1:0] == 2'b01) && cause[XLEN-1];
    assign vector_pc = vectored ? base + (XLEN'(cause[5:0]) << 2) : base;
`else
    assign vector_pc = base;
`endif

    assign unused_cause = ^cause;

endmodule

// File: rtl/csr_trap_seq.sv
// Trap-entry / mret sequencer and single write-port arbiter for the M-mode CSR file.
// Optional vectored trap mode: define CSR_TRAP_VECTORED_EN.
module csr_trap_seq
    import csr_trap_seq_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned IDXW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic            csr_wr_req,
    input  logic [IDXW-1:0] csr_wr_index,
    input  logic [XLEN-1:0] csr_wr_data,
    output logic            csr_wr_gnt,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mstatus_q,
    input  logic [XLEN-1:0] mtvec_q,
    input  logic [XLEN-1:0] mepc_q,
    output logic            csr_we,
    output logic [IDXW-1:0] csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] cause_r, cause_d;
    logic [XLEN-1:0] pc_r, pc_d;
    logic [XLEN-1:0] tgt_r, tgt_d;
    logic [XLEN-1:0] vec_pc;
    logic [XLEN-1:0] status_trap;
    logic [XLEN-1:0] status_mret;

    logic            gnt_c;
    logic            we_c;
    logic [IDXW-1:0] waddr_c;
    logic [XLEN-1:0] wdata_c;
    logic            redir_c;
    logic [XLEN-1:0] redir_pc_c;

    csr_trap_target #(
        .XLEN (XLEN)
    ) u_target (
        .mtvec_q   (mtvec_q),
        .cause     (cause_r),
        .vector_pc (vec_pc)
    );

    // mstatus images written on trap entry and on mret
    always_comb begin
        status_trap = mstatus_q;
        status_trap[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
        status_trap[MSTATUS_MIE]  = 1'b0;
        status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        status_mret = mstatus_q;
        status_mret[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
        status_mret[MSTATUS_MPIE] = 1'b1;
        status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cause_r <= '0;
            pc_r    <= '0;
            tgt_r   <= '0;
        end else begin
            state_q <= state_d;
            cause_r <= cause_d;
            pc_r    <= pc_d;
            tgt_r   <= tgt_d;
        end
    end

    // Next state, latched trap context and raw write-port/redirect drive
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_r;
        pc_d       = pc_r;
        tgt_d      = tgt_r;
        gnt_c      = 1'b0;
        we_c       = 1'b0;
        waddr_c    = '0;
        wdata_c    = '0;
        redir_c    = 1'b0;
        redir_pc_c = '0;

        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    cause_d = trap_cause;
                    pc_d    = trap_pc;
                    state_d = TR_EPC;
                end else if (mret_req) begin
                    state_d = MR_STATUS;
                end else if (csr_wr_req && inst_valid) begin
                    gnt_c   = 1'b1;
                    we_c    = 1'b1;
                    waddr_c = csr_wr_index;
                    wdata_c = csr_wr_data;
                end
            end
            TR_EPC: begin
                we_c    = 1'b1;
                waddr_c = IDXW'(CSR_MEPC);
                wdata_c = pc_r & ~XLEN'(3);
                state_d = TR_CAUSE;
            end
            TR_CAUSE: begin
                we_c    = 1'b1;
                waddr_c = IDXW'(CSR_MCAUSE);
                wdata_c = cause_r;
                state_d = TR_STATUS;
            end
            TR_STATUS: begin
                we_c    = 1'b1;
                waddr_c = IDXW'(CSR_MSTATUS);
                wdata_c = status_trap;
                tgt_d   = vec_pc;
                state_d = REDIR;
            end
            MR_STATUS: begin
                we_c    = 1'b1;
                waddr_c = IDXW'(CSR_MSTATUS);
                wdata_c = status_mret;
                tgt_d   = mepc_q;
                state_d = REDIR;
            end
            REDIR: begin
                redir_c    = 1'b1;
                redir_pc_c = tgt_r;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Everything is forced quiet while reset is held
    assign csr_wr_gnt     = gnt_c & ~rst;
    assign csr_we         = we_c & ~rst;
    assign csr_waddr      = rst ? '0 : waddr_c;
    assign csr_wdata      = rst ? '0 : wdata_c;
    assign redirect_valid = redir_c & ~rst;
    assign redirect_pc    = rst ? '0 : redir_pc_c;
    assign stall          = ~rst & ((state_q != IDLE) | trap_req | mret_req);

endmodule

// File: tb/tb_csr_trap_seq.sv
// Scoreboard bench for csr_trap_seq: stimulus queues expected CSR writes and
// redirects tagged with their cycle; a negedge monitor pops and compares them.
module tb_csr_trap_seq;

    localparam int unsigned XLEN = 64;
    localparam int unsigned IDXW = 12;

    typedef struct {
        int              cyc;
        logic [IDXW-1:0] addr;
        logic [XLEN-1:0] data;
    } wr_t;

    typedef struct {
        int              cyc;
        logic [XLEN-1:0] pc;
    } rd_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            inst_valid;
    logic            csr_wr_req;
    logic [IDXW-1:0] csr_wr_index;
    logic [XLEN-1:0] csr_wr_data;
    logic            csr_wr_gnt;
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret_req;
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic            csr_we;
    logic [IDXW-1:0] csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    wr_t exp_wr[$];
    rd_t exp_rd[$];

    csr_trap_seq #(
        .XLEN (XLEN),
        .IDXW (IDXW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .csr_wr_req     (csr_wr_req),
        .csr_wr_index   (csr_wr_index),
        .csr_wr_data    (csr_wr_data),
        .csr_wr_gnt     (csr_wr_gnt),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .mret_req       (mret_req),
        .mstatus_q      (mstatus_q),
        .mtvec_q        (mtvec_q),
        .mepc_q         (mepc_q),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        inst_valid   = 1'b0;
        csr_wr_req   = 1'b0;
        csr_wr_index = '0;
        csr_wr_data  = '0;
        trap_req     = 1'b0;
        mret_req     = 1'b0;
    endtask

    // Monitor: every observed write/redirect must match the head of its queue
    always @(negedge clk) begin
        if (csr_we) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, none expected (cycle %0d)",
                         csr_waddr, csr_wdata, cyc);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_cycle", XLEN'(cyc), XLEN'(e.cyc));
                chk("wr_addr", XLEN'(csr_waddr), XLEN'(e.addr));
                chk("wr_data", csr_wdata, e.data);
            end
        end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
            wr_t e;
            e = exp_wr.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_write: got none, expected addr %h data %h at cycle %0d",
                     e.addr, e.data, e.cyc);
        end

        if (redirect_valid) begin
            if (exp_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_redirect: got pc %h, none expected (cycle %0d)",
                         redirect_pc, cyc);
            end else begin
                rd_t r;
                r = exp_rd.pop_front();
                chk("redir_cycle", XLEN'(cyc), XLEN'(r.cyc));
                chk("redir_pc", redirect_pc, r.pc);
            end
        end else if (exp_rd.size() > 0 && exp_rd[0].cyc <= cyc) begin
            rd_t r;
            r = exp_rd.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_redirect: got none, expected pc %h at cycle %0d", r.pc, r.cyc);
        end
    end

    // Trap entry: optional simultaneous mret and instruction write must lose
    task automatic run_trap(input logic [XLEN-1:0] cause, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] mst, input logic [XLEN-1:0] mtv,
                            input logic [XLEN-1:0] exp_epc, input logic [XLEN-1:0] exp_status,
                            input logic [XLEN-1:0] exp_vec, input bit contend);
        int c0;
        tick();
        quiet_inputs();
        trap_req   = 1'b1;
        trap_cause = cause;
        trap_pc    = pc;
        mstatus_q  = mst;
        mtvec_q    = mtv;
        if (contend) begin
            mret_req     = 1'b1;
            csr_wr_req   = 1'b1;
            inst_valid   = 1'b1;
            csr_wr_index = 12'hB01;
            csr_wr_data  = 64'hDEAD;
        end
        c0 = cyc;
        exp_wr.push_back('{c0 + 1, 12'h341, exp_epc});
        exp_wr.push_back('{c0 + 2, 12'h342, cause});
        exp_wr.push_back('{c0 + 3, 12'h300, exp_status});
        exp_rd.push_back('{c0 + 4, exp_vec});
        @(negedge clk);
        chk("trap_accept_stall", XLEN'(stall), XLEN'(1));
        chk("trap_accept_gnt", XLEN'(csr_wr_gnt), XLEN'(0));
        for (int k = 1; k <= 5; k++) begin
            tick();
            quiet_inputs();
            @(negedge clk);
            chk("trap_stall", XLEN'(stall), XLEN'((k <= 4) ? 1 : 0));
        end
    endtask

    initial begin
        quiet_inputs();
        trap_cause = '0;
        trap_pc    = '0;
        mstatus_q  = '0;
        mtvec_q    = '0;
        mepc_q     = '0;
        rst        = 1'b1;

        // Requests during reset must all be masked
        tick();
        trap_req   = 1'b1;
        csr_wr_req = 1'b1;
        inst_valid = 1'b1;
        @(negedge clk);
        chk("rst_stall", XLEN'(stall), XLEN'(0));
        chk("rst_gnt", XLEN'(csr_wr_gnt), XLEN'(0));
        chk("rst_we", XLEN'(csr_we), XLEN'(0));
        chk("rst_redir", XLEN'(redirect_valid), XLEN'(0));

        tick();
        rst = 1'b0;
        quiet_inputs();
        @(negedge clk);
        chk("idle_stall", XLEN'(stall), XLEN'(0));

        // Zero-latency instruction write
        tick();
        csr_wr_req   = 1'b1;
        inst_valid   = 1'b1;
        csr_wr_index = 12'hB00;
        csr_wr_data  = 64'h5;
        exp_wr.push_back('{cyc, 12'hB00, 64'h5});
        @(negedge clk);
        chk("inst_gnt", XLEN'(csr_wr_gnt), XLEN'(1));
        chk("inst_stall", XLEN'(stall), XLEN'(0));

        // No grant without inst_valid
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        chk("inst_invalid_gnt", XLEN'(csr_wr_gnt), XLEN'(0));

        run_trap(64'h2, 64'h8000_0106, 64'h8, 64'h8000_0100,
                 64'h8000_0104, 64'h1880, 64'h8000_0100, 1'b0);

        // mret: status write in cycle 1, redirect to mepc in cycle 2
        tick();
        quiet_inputs();
        mret_req  = 1'b1;
        mstatus_q = 64'h80;
        mepc_q    = 64'h8000_0200;
        exp_wr.push_back('{cyc + 1, 12'h300, 64'h1888});
        exp_rd.push_back('{cyc + 2, 64'h8000_0200});
        @(negedge clk);
        chk("mret_accept_stall", XLEN'(stall), XLEN'(1));
        for (int k = 1; k <= 3; k++) begin
            tick();
            quiet_inputs();
            @(negedge clk);
            chk("mret_stall", XLEN'(stall), XLEN'((k <= 2) ? 1 : 0));
        end

        // Trap wins over mret and instruction write in the same cycle
        run_trap(64'h5, 64'h8000_0302, 64'h0, 64'h8000_0100,
                 64'h8000_0300, 64'h1800, 64'h8000_0100, 1'b1);

        // Reset while in TR_CAUSE abandons the rest of the sequence
        tick();
        trap_req   = 1'b1;
        trap_cause = 64'h3;
        trap_pc    = 64'h8000_0500;
        mstatus_q  = 64'h8;
        exp_wr.push_back('{cyc + 1, 12'h341, 64'h8000_0500});
        tick();
        quiet_inputs();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_we", XLEN'(csr_we), XLEN'(0));
        chk("midrst_stall", XLEN'(stall), XLEN'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_stall", XLEN'(stall), XLEN'(0));
        chk("postrst_we", XLEN'(csr_we), XLEN'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("postrst_redir", XLEN'(redirect_valid), XLEN'(0));
        end

        // Interrupt cause with vectored-mode mtvec
`ifdef CSR_TRAP_VECTORED_EN
        run_trap(64'h8000_0000_0000_0007, 64'h8000_0400, 64'h0, 64'h8000_0101,
                 64'h8000_0400, 64'h1800, 64'h8000_011C, 1'b0);
`else
        run_trap(64'h8000_0000_0000_0007, 64'h8000_0400, 64'h0, 64'h8000_0101,
                 64'h8000_0400, 64'h1800, 64'h8000_0100, 1'b0);
`endif

        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        chk("writes_drained", XLEN'(exp_wr.size()), XLEN'(0));
        chk("redirects_drained", XLEN'(exp_rd.size()), XLEN'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
